// File: rtl/pipe_datapath.sv
// pipe_datapath: two-stage execute/writeback datapath with register file, operand bypass and retire counter.
// W holds the result until the consumer takes it; E is purely combinational.
module pipe_datapath #(
    parameter int WIDTH   = 32,
    parameter int REGS    = 32,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(REGS),
    localparam int IW     = 4 + 3 * AW,
    localparam int CW     = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [IW-1:0]    instruct,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] muxout,
    output logic [AW-1:0]    out_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_illegal,
    output logic [CW-1:0]    retire_count
);
    logic [WIDTH-1:0] r_regs [REGS];
    logic             r_valid;
    logic [WIDTH-1:0] r_mux;
    logic [AW-1:0]    r_rd;
    logic             r_ill;
    logic [CW-1:0]    r_cnt;

    logic [3:0]            w_op;
    logic [AW-1:0]         w_rd, w_rs1, w_rs2;
    logic [WIDTH-1:0]      w_a, w_b, w_res;
    logic [WIDTH+2*AW-1:0] w_imm;
    logic                  w_ill, w_pend, w_acc, w_ret;

    assign w_op  = instruct[3:0];
    assign w_rd  = instruct[AW+3:4];
    assign w_rs1 = instruct[2*AW+3:AW+4];
    assign w_rs2 = instruct[3*AW+3:2*AW+4];
    assign w_imm = {{WIDTH{1'b0}}, w_rs1, w_rs2};

    // W will write r_rd on retire; the same condition gates the bypass
    assign w_pend = r_valid && !r_ill && !(ZERO_R0 != 0 && r_rd == '0);
    assign w_a = (ZERO_R0 != 0 && w_rs1 == '0) ? '0 : (w_pend && w_rs1 == r_rd) ? r_mux : r_regs[w_rs1];
    assign w_b = (ZERO_R0 != 0 && w_rs2 == '0) ? '0 : (w_pend && w_rs2 == r_rd) ? r_mux : r_regs[w_rs2];

    assign in_ready     = !r_valid || out_ready;
    assign w_acc        = in_valid && in_ready;
    assign w_ret        = r_valid && out_ready;
    assign out_valid    = r_valid;
    assign muxout       = r_mux;
    assign out_rd       = r_rd;
    assign out_illegal  = r_ill;
    assign retire_count = r_cnt;

    // Shift amounts past WIDTH naturally yield zero / sign fill
    always_comb begin
        w_res = '0;
        w_ill = 1'b0;
        case (w_op)
            4'd0:    w_res = w_a + w_b;
            4'd1:    w_res = w_a - w_b;
            4'd2:    w_res = w_a & w_b;
            4'd3:    w_res = w_a | w_b;
            4'd4:    w_res = w_a ^ w_b;
            4'd5:    w_res = w_a << w_rs2;
            4'd6:    w_res = w_a >> w_rs2;
            4'd7:    w_res = $signed(w_a) >>> w_rs2;
            4'd8:    w_res = w_imm[WIDTH-1:0];
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_mux   <= '0;
            r_rd    <= '0;
            r_ill   <= 1'b0;
            r_cnt   <= '0;
            for (int i = 0; i < REGS; i++) r_regs[i] <= '0;
        end else begin
            if (w_ret) begin
                r_cnt <= r_cnt + CW'(1);
                if (w_pend) r_regs[r_rd] <= r_mux;
            end
            if (w_acc) begin
                r_valid <= 1'b1;
                r_mux   <= w_res;
                r_rd    <= w_rd;
                r_ill   <= w_ill;
            end else if (w_ret) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pipe_datapath.sv
// tb_pipe_datapath: random and directed stimulus against a sequential ISA model, scoreboard-checked.
module tb_pipe_datapath;
    localparam int AW = 5;
    localparam int IW = 4 + 3 * AW;

    logic          clk, reset_n, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [IW-1:0] instruct;
    logic [31:0]   muxout, retire_count;
    logic [AW-1:0] out_rd;

    pipe_datapath dut (
        .clock(clk), .reset_n(reset_n), .instruct(instruct), .in_valid(in_valid),
        .in_ready(in_ready), .muxout(muxout), .out_rd(out_rd), .out_valid(out_valid),
        .out_ready(out_ready), .out_illegal(out_illegal), .retire_count(retire_count)
    );

    typedef struct { logic [31:0] res; logic [4:0] rd; logic ill; } exp_t;
    exp_t        q[$];
    logic [31:0] mregs [32];
    int          checks = 0, errors = 0, tb_retired = 0;
    bit          rnd = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs1, input int rs2);
        return {5'(rs2), 5'(rs1), 5'(rd), 4'(op)};
    endfunction

    function automatic int rr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
    endfunction

    // Architectural model: executes in program order at the moment of acceptance
    task automatic model(input logic [IW-1:0] ins);
        int op, rd, r1, r2;
        logic [31:0] a, b, r;
        logic ill;
        op = int'(ins[3:0]); rd = int'(ins[8:4]); r1 = int'(ins[13:9]); r2 = int'(ins[18:14]);
        a = mregs[r1]; b = mregs[r2]; r = 0; ill = 0;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a << r2;
            6: r = a >> r2;
            7: r = a[31] ? ~((~a) >> r2) : (a >> r2);
            8: r = 32'(r1 * 32 + r2);
            default: ill = 1;
        endcase
        if (!ill && rd != 0) mregs[rd] = r;
        q.push_back('{r, 5'(rd), ill});
    endtask

    task automatic issue(input logic [IW-1:0] ins);
        bit ok;
        ok = 0;
        instruct = ins;
        in_valid = 1;
        for (int n = 0; n < 200 && !ok; n++) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                model(ins);
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("issue_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit          hold;
        logic [31:0] h_mux;
        logic [4:0]  h_rd;
        logic        h_ill;
        exp_t        e;
        hold = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                tb_retired = 0;
                hold = 0;
            end else begin
                chk("in_ready", in_ready, !out_valid || out_ready);
                chk("retire_count", retire_count, 32'(tb_retired));
                if (hold) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_muxout", muxout, h_mux);
                    chk("hold_rd", out_rd, h_rd);
                    chk("hold_illegal", out_illegal, h_ill);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) chk("unexpected_output", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("muxout", muxout, e.res);
                        chk("out_rd", out_rd, e.rd);
                        chk("out_illegal", out_illegal, e.ill);
                    end
                    tb_retired++;
                end
                hold = out_valid && !out_ready;
                h_mux = muxout; h_rd = out_rd; h_ill = out_illegal;
            end
        end
    end

    initial begin
        reset_n = 0; in_valid = 0; instruct = 0; out_ready = 0;
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_illegal", out_illegal, 0);
        chk("rst_count", retire_count, 0);
        chk("rst_muxout", muxout, 0);
        @(negedge clk); #2 reset_n = 1;
        @(posedge clk); #1;
        out_ready = 1;
        issue(enc(8, 1, 0, 5));
        issue(enc(8, 2, 0, 3));
        issue(enc(0, 3, 1, 2));
        idle(2);
        chk("count_after_3", retire_count, 3);
        issue(enc(1, 4, 2, 1));
        issue(enc(7, 5, 4, 31));
        issue(enc(6, 5, 4, 31));
        idle(2);
        // Stall: W full, consumer not ready, next instruction held at the input
        out_ready = 0;
        issue(enc(4, 6, 3, 4));
        instruct = enc(0, 7, 6, 6);
        in_valid = 1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1;
        issue(enc(0, 7, 6, 6));
        issue(enc(12, 3, 1, 2));
        issue(enc(3, 8, 3, 3));
        issue(enc(8, 0, 0, 7));
        issue(enc(0, 6, 0, 0));
        issue(enc(3, 9, 6, 6));
        idle(2);
        rnd = 1;
        repeat (1500) begin
            int op;
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            issue(enc(op, rr(), rr(), rr()));
        end
        rnd = 0;
        out_ready = 1;
        for (int n = 0; n < 50 && q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        chk("drain", q.size(), 0);
        // Reset while W holds an unaccepted result
        out_ready = 0;
        issue(enc(8, 9, 1, 2));
        @(negedge clk);
        chk("pre_reset_valid", out_valid, 1);
        #2 reset_n = 0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_count", retire_count, 0);
        chk("reset_in_ready", in_ready, 1);
        q.delete();
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        @(negedge clk); #2 reset_n = 1;
        @(posedge clk); #1;
        out_ready = 1;
        issue(enc(3, 1, 9, 9));
        issue(enc(0, 2, 3, 4));
        idle(3);
        chk("post_reset_count", retire_count, 2);
        chk("post_reset_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
